mem_result_checker: RTL and testbench

- Synthesizable, parametrised result checker that snoops the MIPS data-memory write bus (memwrite/adr/writedata) inside mips_mem-based systems.
- Compares writes to a designated result address against a loadable table of expected values, in order, under a cycle timeout.
- Reports sticky pass/fail status, mismatch diagnostics and counters for on-chip self-test and bench use.
- Generalises the single fixed check (address FF, data 0D) to N expected values, arbitrary width, configurable address, timeout and strict mode.

---
 rtl/mem_result_checker.sv | 170 +++++++++++++++++
 tb/tb_mem_result_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_result_checker.sv
// Snoops the data-memory write bus and checks writes to one result address
// against a loadable table of expected values, in order, under a cycle timeout.
module mem_result_checker #(
    parameter int               WIDTH      = 8,
    parameter int               NEXP       = 4,
    parameter int               IDXBITS    = 2,
    parameter logic [WIDTH-1:0] RESULT_ADR = 8'hFF,
    parameter int               TIMEOUT    = 500,
    parameter int               CNTBITS    = 16,
    parameter bit               STRICT     = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memwrite,
    input  logic [WIDTH-1:0]   adr,
    input  logic [WIDTH-1:0]   writedata,
    input  logic               exp_we,
    input  logic [IDXBITS-1:0] exp_idx,
    input  logic [WIDTH-1:0]   exp_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic               timeout,
    output logic [IDXBITS-1:0] err_idx,
    output logic [WIDTH-1:0]   err_data,
    output logic [CNTBITS-1:0] cycles,
    output logic [CNTBITS-1:0] other_writes
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [IDXBITS-1:0] LAST_IDX  = IDXBITS'(NEXP - 1);
    localparam logic [CNTBITS-1:0] TO_LAST   = CNTBITS'(TIMEOUT - 1);

    state_t               state_reg, state_next;
    logic [IDXBITS-1:0]   ptr_reg, ptr_next;
    logic [CNTBITS-1:0]   cycles_reg, cycles_next;
    logic [CNTBITS-1:0]   other_reg, other_next;
    logic [IDXBITS-1:0]   err_idx_reg, err_idx_next;
    logic [WIDTH-1:0]     err_data_reg, err_data_next;
    logic                 timeout_reg, timeout_next;

    logic [WIDTH-1:0]     exp_tab_reg [NEXP];
    logic [WIDTH-1:0]     exp_cur;
    logic                 load_en;
    logic                 hit;
    logic                 stray;
    logic                 match;
    logic                 at_last;
    logic                 to_edge;

    // The table only accepts loads while idle so a running check sees a stable table.
    assign load_en = exp_we && (state_reg == IDLE);

    generate
        for (genvar gi = 0; gi < NEXP; gi++) begin : g_tab
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    exp_tab_reg[gi] <= '0;
                end else if (load_en && (exp_idx == IDXBITS'(gi))) begin
                    exp_tab_reg[gi] <= exp_data;
                end
            end
        end
    endgenerate

    // Explicit mux keeps the pointer from ever addressing past the table.
    always_comb begin
        exp_cur = '0;
        for (int i = 0; i < NEXP; i++) begin
            if (ptr_reg == IDXBITS'(i)) begin
                exp_cur = exp_tab_reg[i];
            end
        end
    end

    assign hit     = memwrite && (adr == RESULT_ADR);
    assign stray   = memwrite && (adr != RESULT_ADR);
    assign match   = (writedata == exp_cur);
    assign at_last = (ptr_reg == LAST_IDX);
    assign to_edge = (cycles_reg == TO_LAST);

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        cycles_next   = cycles_reg;
        other_next    = other_reg;
        err_idx_next  = err_idx_reg;
        err_data_next = err_data_reg;
        timeout_next  = timeout_reg;

        if (state_reg == RUN) begin
            if (!(&cycles_reg)) begin
                cycles_next = cycles_reg + 1'b1;
            end
            if (stray && !(&other_reg)) begin
                other_next = other_reg + 1'b1;
            end

            // A non-final match does not decide the run, so timeout still applies on that edge.
            if (hit && match && at_last) begin
                state_next = PASS;
            end else if (hit && !match) begin
                state_next    = FAIL;
                err_idx_next  = ptr_reg;
                err_data_next = writedata;
            end else if (stray && STRICT) begin
                state_next    = FAIL;
                err_idx_next  = ptr_reg;
                err_data_next = writedata;
            end else if (to_edge) begin
                state_next    = FAIL;
                timeout_next  = 1'b1;
                err_idx_next  = ptr_reg;
                err_data_next = '0;
            end else if (hit && match) begin
                ptr_next = ptr_reg + 1'b1;
            end
        end

        // start from any state begins a fresh run and overrides whatever RUN decided.
        if (start) begin
            state_next    = RUN;
            ptr_next      = '0;
            cycles_next   = '0;
            other_next    = '0;
            err_idx_next  = '0;
            err_data_next = '0;
            timeout_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            cycles_reg   <= '0;
            other_reg    <= '0;
            err_idx_reg  <= '0;
            err_data_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            cycles_reg   <= cycles_next;
            other_reg    <= other_next;
            err_idx_reg  <= err_idx_next;
            err_data_reg <= err_data_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign busy         = (state_reg == RUN);
    assign pass         = (state_reg == PASS);
    assign fail         = (state_reg == FAIL);
    assign done         = pass || fail;
    assign timeout      = timeout_reg;
    assign err_idx      = err_idx_reg;
    assign err_data     = err_data_reg;
    assign cycles       = cycles_reg;
    assign other_writes = other_reg;

endmodule

// File: tb/tb_mem_result_checker.sv
// Directed bench for mem_result_checker: four configurations, a vector table
// for the three-entry sequence and hand sequences for timeout/reset/restart.
module tb_mem_result_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Bundle a drives the single-entry checkers, bundle b the three-entry ones.
    logic       a_start = 0, a_we = 0, a_mw = 0;
    logic [1:0] a_idx = 0;
    logic [7:0] a_ed = 0, a_adr = 0, a_wd = 0;
    logic       b_start = 0, b_we = 0, b_mw = 0;
    logic [1:0] b_idx = 0;
    logic [7:0] b_ed = 0, b_adr = 0, b_wd = 0;

    logic        o1_busy, o1_done, o1_pass, o1_fail, o1_to;
    logic [1:0]  o1_eidx;
    logic [7:0]  o1_edata;
    logic [15:0] o1_cyc, o1_oth;
    logic        ot_busy, ot_done, ot_pass, ot_fail, ot_to;
    logic [1:0]  ot_eidx;
    logic [7:0]  ot_edata;
    logic [15:0] ot_cyc, ot_oth;
    logic        o3_busy, o3_done, o3_pass, o3_fail, o3_to;
    logic [1:0]  o3_eidx;
    logic [7:0]  o3_edata;
    logic [15:0] o3_cyc, o3_oth;
    logic        os_busy, os_done, os_pass, os_fail, os_to;
    logic [1:0]  os_eidx;
    logic [7:0]  os_edata;
    logic [15:0] os_cyc, os_oth;

    mem_result_checker #(.WIDTH(8), .NEXP(1), .IDXBITS(2), .RESULT_ADR(8'hFF),
                         .TIMEOUT(500), .CNTBITS(16), .STRICT(1'b0)) u1 (
        .clk(clk), .reset(reset), .memwrite(a_mw), .adr(a_adr), .writedata(a_wd),
        .exp_we(a_we), .exp_idx(a_idx), .exp_data(a_ed), .start(a_start),
        .busy(o1_busy), .done(o1_done), .pass(o1_pass), .fail(o1_fail),
        .timeout(o1_to), .err_idx(o1_eidx), .err_data(o1_edata),
        .cycles(o1_cyc), .other_writes(o1_oth));

    mem_result_checker #(.WIDTH(8), .NEXP(1), .IDXBITS(2), .RESULT_ADR(8'hFF),
                         .TIMEOUT(20), .CNTBITS(16), .STRICT(1'b0)) ut (
        .clk(clk), .reset(reset), .memwrite(a_mw), .adr(a_adr), .writedata(a_wd),
        .exp_we(a_we), .exp_idx(a_idx), .exp_data(a_ed), .start(a_start),
        .busy(ot_busy), .done(ot_done), .pass(ot_pass), .fail(ot_fail),
        .timeout(ot_to), .err_idx(ot_eidx), .err_data(ot_edata),
        .cycles(ot_cyc), .other_writes(ot_oth));

    mem_result_checker #(.WIDTH(8), .NEXP(3), .IDXBITS(2), .RESULT_ADR(8'hFF),
                         .TIMEOUT(500), .CNTBITS(16), .STRICT(1'b0)) u3 (
        .clk(clk), .reset(reset), .memwrite(b_mw), .adr(b_adr), .writedata(b_wd),
        .exp_we(b_we), .exp_idx(b_idx), .exp_data(b_ed), .start(b_start),
        .busy(o3_busy), .done(o3_done), .pass(o3_pass), .fail(o3_fail),
        .timeout(o3_to), .err_idx(o3_eidx), .err_data(o3_edata),
        .cycles(o3_cyc), .other_writes(o3_oth));

    mem_result_checker #(.WIDTH(8), .NEXP(3), .IDXBITS(2), .RESULT_ADR(8'hFF),
                         .TIMEOUT(500), .CNTBITS(16), .STRICT(1'b1)) us (
        .clk(clk), .reset(reset), .memwrite(b_mw), .adr(b_adr), .writedata(b_wd),
        .exp_we(b_we), .exp_idx(b_idx), .exp_data(b_ed), .start(b_start),
        .busy(os_busy), .done(os_done), .pass(os_pass), .fail(os_fail),
        .timeout(os_to), .err_idx(os_eidx), .err_data(os_edata),
        .cycles(os_cyc), .other_writes(os_oth));

    typedef struct {
        logic       st, we;
        logic [1:0] idx;
        logic [7:0] ed;
        logic       mw;
        logic [7:0] adr, wd;
        logic       e_busy, e_pass, e_fail;
        logic [15:0] e_other;
        logic       s_fail;
        logic [1:0] s_eidx;
        logic [7:0] s_edata;
    } vec_t;

    vec_t vecs [11];
    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_pulse_start();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic a_write(input logic [7:0] ad, input logic [7:0] d);
        a_mw = 1'b1; a_adr = ad; a_wd = d;
        tick();
        a_mw = 1'b0; a_adr = 8'h00; a_wd = 8'h00;
    endtask

    task automatic b_write(input logic [7:0] ad, input logic [7:0] d);
        b_mw = 1'b1; b_adr = ad; b_wd = d;
        tick();
        b_mw = 1'b0; b_adr = 8'h00; b_wd = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0,1'b1,2'd0,8'h05,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,16'd0, 1'b0,2'd0,8'h00};
        vecs[1]  = '{1'b0,1'b1,2'd1,8'h08,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,16'd0, 1'b0,2'd0,8'h00};
        vecs[2]  = '{1'b0,1'b1,2'd2,8'h0D,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,16'd0, 1'b0,2'd0,8'h00};
        vecs[3]  = '{1'b0,1'b1,2'd3,8'h77,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,16'd0, 1'b0,2'd0,8'h00};
        vecs[4]  = '{1'b1,1'b0,2'd0,8'h00,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,16'd0, 1'b0,2'd0,8'h00};
        vecs[5]  = '{1'b0,1'b0,2'd0,8'h00,1'b1,8'hFF,8'h05, 1'b1,1'b0,1'b0,16'd0, 1'b0,2'd0,8'h00};
        vecs[6]  = '{1'b0,1'b0,2'd0,8'h00,1'b1,8'h10,8'h33, 1'b1,1'b0,1'b0,16'd1, 1'b1,2'd1,8'h33};
        vecs[7]  = '{1'b0,1'b0,2'd0,8'h00,1'b1,8'hFF,8'h08, 1'b1,1'b0,1'b0,16'd1, 1'b1,2'd1,8'h33};
        vecs[8]  = '{1'b0,1'b0,2'd0,8'h00,1'b1,8'hFF,8'h0D, 1'b0,1'b1,1'b0,16'd1, 1'b1,2'd1,8'h33};
        vecs[9]  = '{1'b0,1'b0,2'd0,8'h00,1'b0,8'h00,8'h00, 1'b0,1'b1,1'b0,16'd1, 1'b1,2'd1,8'h33};
        vecs[10] = '{1'b0,1'b0,2'd0,8'h00,1'b1,8'h10,8'h44, 1'b0,1'b1,1'b0,16'd1, 1'b1,2'd1,8'h33};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", o1_done, 0);
        chk("rst_busy", o3_busy, 0);
        chk("rst_cycles", o1_cyc, 0);
        reset = 1'b0;
        tick();

        // Single-entry pass after 10 idle RUN cycles
        a_we = 1'b1; a_idx = 2'd0; a_ed = 8'h0D; tick();
        a_idx = 2'd1; a_ed = 8'h55; tick();
        a_we = 1'b0; a_idx = 2'd0; a_ed = 8'h00;
        a_pulse_start();
        chk("t1_busy", o1_busy, 1);
        repeat (10) tick();
        a_write(8'hFF, 8'h0D);
        $display("t1: single-entry match FF/0D");
        chk("t1_pass", o1_pass, 1);
        chk("t1_done", o1_done, 1);
        chk("t1_fail", o1_fail, 0);
        chk("t1_cycles", o1_cyc, 11);
        chk("t1_busy_after", o1_busy, 0);

        // Single-entry mismatch
        a_pulse_start();
        a_write(8'hFF, 8'h0C);
        $display("t2: single-entry mismatch FF/0C");
        chk("t2_fail", o1_fail, 1);
        chk("t2_pass", o1_pass, 0);
        chk("t2_err_idx", o1_eidx, 0);
        chk("t2_err_data", o1_edata, 8'h0C);
        chk("t2_timeout", o1_to, 0);

        // Restart while RUN clears counters
        a_pulse_start();
        repeat (5) tick();
        chk("rs_cycles5", o1_cyc, 5);
        a_pulse_start();
        $display("t3: restart during RUN");
        chk("rs_cycles0", o1_cyc, 0);
        chk("rs_busy", o1_busy, 1);

        // Timeout with TIMEOUT=20
        repeat (19) tick();
        chk("to_busy19", ot_busy, 1);
        chk("to_fail19", ot_fail, 0);
        tick();
        $display("t4: timeout after 20 cycles");
        chk("to_fail", ot_fail, 1);
        chk("to_flag", ot_to, 1);
        chk("to_err_data", ot_edata, 0);
        chk("to_err_idx", ot_eidx, 0);
        chk("to_cycles", ot_cyc, 20);
        repeat (3) tick();
        chk("to_frozen", ot_cyc, 20);

        // Final match on the timeout edge
        a_pulse_start();
        repeat (19) tick();
        a_write(8'hFF, 8'h0D);
        $display("t5: final match on timeout edge");
        chk("tp_pass", ot_pass, 1);
        chk("tp_timeout", ot_to, 0);
        chk("tp_cycles", ot_cyc, 20);

        // Mismatch on the timeout edge
        a_pulse_start();
        repeat (19) tick();
        a_write(8'hFF, 8'h0C);
        $display("t6: mismatch on timeout edge");
        chk("tm_fail", ot_fail, 1);
        chk("tm_timeout", ot_to, 0);
        chk("tm_err_data", ot_edata, 8'h0C);

        // Three-entry table: STRICT=0 (u3) and STRICT=1 (us) side by side
        for (int i = 0; i < 11; i++) begin
            b_start = vecs[i].st; b_we = vecs[i].we; b_idx = vecs[i].idx; b_ed = vecs[i].ed;
            b_mw = vecs[i].mw; b_adr = vecs[i].adr; b_wd = vecs[i].wd;
            tick();
            $display("vec %0d: st=%0b we=%0b mw=%0b adr=%02h wd=%02h", i,
                     vecs[i].st, vecs[i].we, vecs[i].mw, vecs[i].adr, vecs[i].wd);
            chk($sformatf("v%0d_busy", i), o3_busy, vecs[i].e_busy);
            chk($sformatf("v%0d_pass", i), o3_pass, vecs[i].e_pass);
            chk($sformatf("v%0d_fail", i), o3_fail, vecs[i].e_fail);
            chk($sformatf("v%0d_other", i), o3_oth, vecs[i].e_other);
            chk($sformatf("v%0d_s_fail", i), os_fail, vecs[i].s_fail);
            chk($sformatf("v%0d_s_eidx", i), os_eidx, vecs[i].s_eidx);
            chk($sformatf("v%0d_s_edata", i), os_edata, vecs[i].s_edata);
        end
        b_start = 0; b_we = 0; b_idx = 0; b_ed = 0; b_mw = 0; b_adr = 0; b_wd = 0;

        // Asynchronous reset mid-RUN after one match
        b_start = 1'b1; tick(); b_start = 1'b0;
        b_write(8'hFF, 8'h05);
        chk("mr_busy_pre", o3_busy, 1);
        reset = 1'b1;
        #1;
        $display("t7: reset asserted mid-run");
        chk("mr_busy", o3_busy, 0);
        chk("mr_done", o3_done, 0);
        chk("mr_cycles", o3_cyc, 0);
        chk("mr_err_data", os_edata, 0);
        chk("mr_u1_done", o1_done, 0);
        tick();
        reset = 1'b0;
        tick();

        // Cleared table: all-zero writes now pass the three-entry checker
        b_start = 1'b1; tick(); b_start = 1'b0;
        b_write(8'hFF, 8'h00);
        b_write(8'hFF, 8'h00);
        b_write(8'hFF, 8'h00);
        $display("t8: cleared table accepts zeros");
        chk("clr_pass", o3_pass, 1);

        // Load and start in the same IDLE cycle
        a_start = 1'b1; a_we = 1'b1; a_idx = 2'd0; a_ed = 8'h0D;
        tick();
        a_start = 1'b0; a_we = 1'b0; a_ed = 8'h00;
        a_write(8'hFF, 8'h0D);
        $display("t9: load+start then FF/0D");
        chk("ls_pass", o1_pass, 1);

        // Restart from PASS; exp_we in RUN must not alter the table
        a_pulse_start();
        chk("rp_busy", o1_busy, 1);
        chk("rp_pass", o1_pass, 0);
        chk("rp_cycles", o1_cyc, 0);
        a_we = 1'b1; a_idx = 2'd0; a_ed = 8'h99; tick();
        a_we = 1'b0; a_ed = 8'h00;
        a_write(8'hFF, 8'h0D);
        $display("t10: exp_we during RUN ignored");
        chk("we_pass", o1_pass, 1);
        chk("we_fail", o1_fail, 0);
        chk("we_cycles", o1_cyc, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
